// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback arbiter slice.
package wb_pkg;

    // LD_PRIO: loads win ties; ALU_FORCE: ALU wins ties until it is served.
    typedef enum logic [0:0] {
        LD_PRIO   = 1'b0,
        ALU_FORCE = 1'b1
    } wb_arb_state_t;

    // Consecutive load grants tolerated while an ALU result waits.
    localparam int unsigned STARVE_MAX_DEFAULT = 3;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register outstanding-load mask used by decode for load-use stalls.
module wb_scoreboard #(
    parameter int unsigned REGBITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_valid,
    input  logic [REGBITS-1:0]    set_rd,
    input  logic                  clr_valid,
    input  logic [REGBITS-1:0]    clr_rd,
    output logic [2**REGBITS-1:0] pending
);

    logic [2**REGBITS-1:0] pending_d;

    // Clear first so a same-index issue in the same cycle overrides the return.
    always_comb begin
        pending_d = pending;
        if (clr_valid) begin
            pending_d[clr_rd] = 1'b0;
        end
        if (set_valid && (set_rd != '0)) begin
            pending_d[set_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Mask register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: load priority with ALU anti-starvation,
// x0 write suppression and a pending-load scoreboard.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned REGBITS    = 5,
    parameter int unsigned LOGSIZE    = 64,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REGBITS-1:0]    alu_rd,
    input  logic [LOGSIZE-1:0]    alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REGBITS-1:0]    ld_rd,
    input  logic [LOGSIZE-1:0]    ld_data,
    input  logic                  ld_issue_valid,
    input  logic [REGBITS-1:0]    ld_issue_rd,
    output logic                  wr_en,
    output logic [REGBITS-1:0]    wr_rd,
    output logic [LOGSIZE-1:0]    wr_data,
    output logic [2**REGBITS-1:0] pending
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    wb_arb_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          grant_alu, grant_ld;

    // Grant selection; depends only on valids and state, never on ld_issue_*.
    always_comb begin
        alu_ready = 1'b0;
        ld_ready  = 1'b0;
        if (!rst) begin
            if (state_q == ALU_FORCE) begin
                if (alu_valid)     alu_ready = 1'b1;
                else if (ld_valid) ld_ready  = 1'b1;
            end else begin
                if (ld_valid)       ld_ready  = 1'b1;
                else if (alu_valid) alu_ready = 1'b1;
            end
        end
    end

    assign grant_alu = alu_valid & alu_ready;
    assign grant_ld  = ld_valid & ld_ready;

    // Starvation counter and state transitions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!alu_valid || grant_alu) begin
            cnt_d = '0;
        end else if (grant_ld) begin
            cnt_d = cnt_q + 1'b1;
        end
        case (state_q)
            LD_PRIO: begin
                // Switch on the same edge the limit is hit so the next grant goes to ALU.
                if (cnt_d == CW'(STARVE_MAX)) state_d = ALU_FORCE;
            end
            ALU_FORCE: begin
                if (grant_alu || !alu_valid) begin
                    state_d = LD_PRIO;
                    cnt_d   = '0;
                end
            end
            default: state_d = LD_PRIO;
        endcase
    end

    // State, counter and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LD_PRIO;
            cnt_q   <= '0;
            wr_en   <= 1'b0;
            wr_rd   <= '0;
            wr_data <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_en   <= 1'b0;
            if (grant_ld) begin
                wr_en   <= (ld_rd != '0);
                wr_rd   <= ld_rd;
                wr_data <= ld_data;
            end else if (grant_alu) begin
                wr_en   <= (alu_rd != '0);
                wr_rd   <= alu_rd;
                wr_data <= alu_data;
            end
        end
    end

    wb_scoreboard #(
        .REGBITS (REGBITS)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_valid (ld_issue_valid),
        .set_rd    (ld_issue_rd),
        .clr_valid (grant_ld),
        .clr_rd    (ld_rd),
        .pending   (pending)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table plus scoreboard queue.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, ld_valid, ld_ready, ld_issue_valid;
    logic [4:0]  alu_rd, ld_rd, ld_issue_rd, wr_rd;
    logic [63:0] alu_data, ld_data, wr_data;
    logic        wr_en;
    logic [31:0] pending;

    wb_arbiter #(
        .REGBITS    (5),
        .LOGSIZE    (64),
        .STARVE_MAX (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_rd          (ld_rd),
        .ld_data        (ld_data),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_rd    (ld_issue_rd),
        .wr_en          (wr_en),
        .wr_rd          (wr_rd),
        .wr_data        (wr_data),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          av;
        logic [4:0]  ard;
        logic [63:0] adata;
        bit          lv;
        logic [4:0]  lrd;
        logic [63:0] ldata;
        bit          iv;
        logic [4:0]  ird;
        bit          ear;
        bit          elr;
    } vec_t;

    typedef struct {
        bit          en;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [31:0] pend;
    } exp_t;

    vec_t        tbl[$];
    exp_t        expq[$];
    int          errors = 0;
    int          checks = 0;
    logic [4:0]  m_rd   = '0;
    logic [63:0] m_data = '0;
    logic [31:0] m_pend = '0;

    function automatic vec_t v(bit r, bit av, int ard, logic [63:0] adata, bit lv, int lrd,
                               logic [63:0] ldata, bit iv, int ird, bit ear, bit elr);
        vec_t t;
        t.rst = r;   t.av = av;   t.ard = 5'(ard);   t.adata = adata;
        t.lv = lv;   t.lrd = 5'(lrd); t.ldata = ldata;
        t.iv = iv;   t.ird = 5'(ird); t.ear = ear;   t.elr = elr;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, check readies, predict and then compare the registered outputs.
    task automatic step(input vec_t t);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst = t.rst;
        alu_valid = t.av; alu_rd = t.ard; alu_data = t.adata;
        ld_valid = t.lv;  ld_rd = t.lrd;  ld_data = t.ldata;
        ld_issue_valid = t.iv; ld_issue_rd = t.ird;
        #1;
        chk("alu_ready", alu_ready, t.ear);
        chk("ld_ready", ld_ready, t.elr);
        if (t.rst) begin
            m_rd = '0; m_data = '0; m_pend = '0;
            e.en = 1'b0;
        end else begin
            e.en = 1'b0;
            if (t.elr && t.lv) begin
                e.en = (t.lrd != 0); m_rd = t.lrd; m_data = t.ldata;
                m_pend[t.lrd] = 1'b0;
            end else if (t.ear && t.av) begin
                e.en = (t.ard != 0); m_rd = t.ard; m_data = t.adata;
            end
            if (t.iv && t.ird != 0) m_pend[t.ird] = 1'b1;
            m_pend[0] = 1'b0;
        end
        e.rd = m_rd; e.data = m_data; e.pend = m_pend;
        expq.push_back(e);
        @(posedge clk);
        #1;
        if (expq.size() == 0) begin
            chk("queue_underflow", 1, 0);
        end else begin
            got = expq.pop_front();
            chk("wr_en", wr_en, got.en);
            chk("wr_rd", wr_rd, got.rd);
            chk("wr_data", wr_data, got.data);
            chk("pending", pending, got.pend);
        end
    endtask

    vec_t idle;

    initial begin
        rst = 1'b1; alu_valid = 0; ld_valid = 0; ld_issue_valid = 0;
        alu_rd = '0; ld_rd = '0; ld_issue_rd = '0; alu_data = '0; ld_data = '0;
        idle = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset with both requesters valid: nothing granted.
        tbl.push_back(v(1, 1, 6, 'hBB, 1, 5, 'hAA, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 6, 'hBB, 1, 5, 'hAA, 1, 4, 0, 0));
        // Load priority, then the held ALU request.
        tbl.push_back(v(0, 1, 6, 'hBB, 1, 5, 'hAA, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 6, 'hBB, 0, 0, 0, 0, 0, 1, 0));
        // Starvation bound: L L L A L L L A.
        tbl.push_back(v(0, 1, 6, 'hB0, 1, 1, 'h11, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 6, 'hB0, 1, 2, 'h22, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 6, 'hB0, 1, 3, 'h33, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 6, 'hB0, 1, 4, 'h44, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 7, 'hB1, 1, 4, 'h44, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 7, 'hB1, 1, 5, 'h55, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 7, 'hB1, 1, 8, 'h88, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 7, 'hB1, 1, 9, 'h99, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 9, 'h99, 0, 0, 0, 1));
        // x0 suppression for both paths.
        tbl.push_back(v(0, 1, 0, 'hFF, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 'h77, 0, 0, 0, 1));
        // Write then idle hold for 5 cycles.
        tbl.push_back(v(0, 1, 3, 'h1234, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(idle);
        // Mid-operation reset with pending = 0x10.
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0));
        tbl.push_back(v(1, 1, 6, 'hC0, 1, 4, 'hD0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 6, 'hC0, 1, 5, 'hD5, 0, 0, 0, 1));
        // Reset mid-starvation must clear the counter: L L L A afterwards.
        tbl.push_back(v(0, 1, 6, 'hC0, 1, 1, 'hD1, 0, 0, 0, 1));
        tbl.push_back(v(1, 1, 6, 'hC0, 1, 2, 'hD2, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 6, 'hC0, 1, 2, 'hD2, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 6, 'hC0, 1, 3, 'hD3, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 6, 'hC0, 1, 4, 'hD4, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 6, 'hC0, 1, 5, 'hD5, 0, 0, 1, 0));
        tbl.push_back(idle);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Scoreboard set-wins sequence on rd 7.
        step(v(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0));
        chk("pend7_after_issue", pending[7], 1);
        for (int i = 0; i < 3; i++) step(idle);
        step(v(0, 0, 0, 0, 1, 7, 'h700, 1, 7, 0, 1));
        chk("pend7_set_wins", pending[7], 1);
        for (int i = 0; i < 3; i++) step(idle);
        step(v(0, 0, 0, 0, 1, 7, 'h701, 0, 0, 0, 1));
        chk("pend7_cleared", pending[7], 0);
        step(idle);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-port arbiter and sequencer for the register file in front of the writeback stage. It shares the single register-file write port between two requesters:

- the ALU result path;
- the load-return path from memory.

It enforces anti-starvation for ALU results and suppresses writes to x0. It also keeps a pending-load scoreboard that the decode stage uses for load-use hazard stalls. It sits between execute/memory and the register file, replacing direct writeback muxing.

## Interface
Parameters:
- REGBITS, 5, register index width
- LOGSIZE, 64, data width
- STARVE_MAX, 3, consecutive load grants allowed while ALU waits (min 1)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result request
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  REGBITS  ALU destination
- alu_data  in  LOGSIZE  ALU result
- ld_valid  in  1  load-return request
- ld_ready  out  1  load data accepted this cycle
- ld_rd  in  REGBITS  load destination
- ld_data  in  LOGSIZE  load data
- ld_issue_valid  in  1  load issued to memory this cycle
- ld_issue_rd  in  REGBITS  destination of issued load
- wr_en  out  1  register-file write enable (registered)
- wr_rd  out  REGBITS  register-file write index (registered)
- wr_data  out  LOGSIZE  register-file write data (registered)
- pending  out  2**REGBITS  per-register outstanding-load mask

## Operation
Handshakes:
- A transfer occurs when valid && ready in the same cycle.
- ready is combinational from the valid inputs and the current state.
- Requesters hold rd and data stable until accepted.
- At most one of alu_ready and ld_ready is high in any cycle.

FSM states (shared package enum): LD_PRIO, ALU_FORCE.
- LD_PRIO:
  - if ld_valid, grant load;
  - else if alu_valid, grant ALU.
- ALU_FORCE:
  - if alu_valid, grant ALU;
  - else if ld_valid, grant load.
- Starvation counter, width clog2(STARVE_MAX+1):
  - increments on each load grant made while alu_valid is high;
  - clears on any ALU grant;
  - clears on any cycle with alu_valid low.
- LD_PRIO -> ALU_FORCE when the counter reaches STARVE_MAX.
- ALU_FORCE -> LD_PRIO on an ALU grant, or on a cycle with alu_valid low.
- Counter clears on entering LD_PRIO.

Write port:
- A granted transfer sets wr_rd and wr_data from the winner on the next edge.
- wr_en = 1, except when the winner's rd == 0: then wr_en = 0, and the transfer is still consumed.
- With no grant, wr_en = 0; wr_rd and wr_data hold their previous values.

Scoreboard (pending):
- An issue with ld_issue_valid && ld_issue_rd != 0 sets pending[ld_issue_rd].
- An accepted load return clears pending[ld_rd].
- If the same index is issued and returned in one cycle, the set wins.
- pending[0] is constantly 0.
- ALU grants never modify pending.
- pending is registered: updates are visible the cycle after the event.

Reset:
- Mid-operation reset discards in-flight grants.
- wr_en = 0, wr_rd = 0, wr_data = 0, pending = 0, state = LD_PRIO, counter = 0.
- alu_ready and ld_ready are 0 during the rst cycle.

## Timing
- Grant to register-file write: 1 cycle. Transfer at edge N is visible on wr_* after edge N+1.
- Throughput: one write per cycle.
- Maximum ALU wait with both requesters continuously valid: STARVE_MAX cycles.
- Load wait is bounded by 1 cycle per forced ALU grant.
- Issue to pending set: 1 cycle. Load accept to pending clear: 1 cycle.
- No combinational path from ld_issue_* to any ready.

## Structure
- Shared package wb_pkg holds:
  - state enum wb_arb_state_t {LD_PRIO, ALU_FORCE};
  - default STARVE_MAX constant.
- Sub-module wb_scoreboard owns:
  - the pending register array;
  - set/clear logic with set-wins priority;
  - x0 masking.
- wb_arbiter holds the FSM, the counter, grant logic and the output register.

## Test plan
- Reset mid-transfer: assert rst while both valid and pending = 0x10 -> next cycle wr_en = 0, pending = 0, both ready low during rst, state LD_PRIO.
- Load priority: ld_valid (rd 5, data 0xAA) and alu_valid (rd 6, data 0xBB) in the same cycle, STARVE_MAX = 3 -> ld_ready = 1, alu_ready = 0; next cycle wr_en = 1, wr_rd = 5, wr_data = 0xAA.
- Starvation bound: both continuously valid, STARVE_MAX = 3 -> grants L, L, L, A, L, L, L, A; ALU write lands 1 cycle after the 4th grant.
- x0 suppression: alu_valid with rd 0, data 0xFF -> alu_ready = 1; next cycle wr_en = 0.
- Scoreboard: issue rd 7 at cycle 0 -> pending[7] = 1 from cycle 1. Load return for rd 7 accepted at cycle 4 together with a new issue for rd 7 -> pending[7] stays 1. Return for rd 7 accepted at cycle 8 with no issue -> pending[7] = 0 at cycle 9.
- Idle/hold: no valids for 5 cycles after a write of rd 3, data 0x1234 -> wr_en = 0, wr_rd = 3, wr_data = 0x1234 held.
